// File: rtl/wb_retire_if.sv
// MEM->WB bundle handshake: MEM offers up to LANES program-ordered instructions,
// the writeback stage answers with wb_allow_in.
interface wb_retire_if #(
    parameter int XLEN  = 32,
    parameter int LANES = 2
);
    logic                  mem_to_wb_valid;
    logic                  wb_allow_in;
    logic [LANES-1:0]      in_lane_valid;
    logic [LANES*XLEN-1:0] in_pc;
    logic [LANES*XLEN-1:0] in_result;
    logic [LANES-1:0]      in_rf_wr_en;
    logic [LANES*5-1:0]    in_rf_waddr;
    logic [LANES-1:0]      in_ebreak;

    modport master (
        output mem_to_wb_valid, in_lane_valid, in_pc, in_result,
               in_rf_wr_en, in_rf_waddr, in_ebreak,
        input  wb_allow_in
    );

    modport slave (
        input  mem_to_wb_valid, in_lane_valid, in_pc, in_result,
               in_rf_wr_en, in_rf_waddr, in_ebreak,
        output wb_allow_in
    );
endinterface

// File: rtl/wb_retire_stage.sv
// Multi-lane writeback/retire stage: holds one bundle, writes the register file
// (youngest writer wins), stalls on the commit trace and halts on a retired ebreak.
module wb_retire_stage #(
    parameter int XLEN  = 32,
    parameter int LANES = 2,
    parameter int CNT_W = $clog2(LANES+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_retire_if.slave            mem,
    input  logic                  trace_ready,
    output logic                  wb_valid,
    output logic [LANES-1:0]      rf_we,
    output logic [LANES*5-1:0]    rf_waddr,
    output logic [LANES*XLEN-1:0] rf_wdata,
    output logic                  commit,
    output logic [CNT_W-1:0]      commit_cnt,
    output logic [XLEN-1:0]       commit_pc,
    output logic [XLEN-1:0]       prev_commit_pc,
    output logic [63:0]           instret,
    output logic                  halt
);
    logic                  vld_p1;
    logic [LANES-1:0]      lane_vld_p1;
    logic [LANES*XLEN-1:0] pc_p1;
    logic [LANES*XLEN-1:0] result_p1;
    logic [LANES-1:0]      wr_en_p1;
    logic [LANES*5-1:0]    waddr_p1;
    logic [LANES-1:0]      ebreak_p1;

    logic                  accept;
    logic                  fire;
    logic                  seen_ebreak;
    logic                  halt_set;
    logic [LANES-1:0]      kill;
    logic [LANES-1:0]      retire;
    logic [LANES-1:0]      we;
    logic [CNT_W-1:0]      cnt;
    logic [XLEN-1:0]       cpc;

    assign mem.wb_allow_in = !halt && (!vld_p1 || trace_ready);
    assign accept          = mem.wb_allow_in && mem.mem_to_wb_valid;

    always_comb begin
        fire        = vld_p1 && trace_ready && !halt;
        kill        = '0;
        seen_ebreak = 1'b0;
        // Lanes younger than a valid ebreak are squashed even though the ebreak retires.
        for (int i = 0; i < LANES; i++) begin
            kill[i] = seen_ebreak;
            if (lane_vld_p1[i] && ebreak_p1[i])
                seen_ebreak = 1'b1;
        end
        retire   = {LANES{fire}} & lane_vld_p1 & ~kill;
        halt_set = |(retire & ebreak_p1);

        cnt = '0;
        cpc = '0;
        for (int i = 0; i < LANES; i++) begin
            if (retire[i]) begin
                cnt = cnt + CNT_W'(1);
                cpc = pc_p1[i*XLEN +: XLEN];
            end
        end

        we = '0;
        for (int i = 0; i < LANES; i++) begin
            we[i] = retire[i] && wr_en_p1[i] && (waddr_p1[i*5 +: 5] != 5'd0);
            for (int k = i + 1; k < LANES; k++) begin
                if (retire[k] && wr_en_p1[k] && (waddr_p1[k*5 +: 5] == waddr_p1[i*5 +: 5]))
                    we[i] = 1'b0;
            end
        end
    end

    // Stage p1: control state
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1         <= 1'b0;
            halt           <= 1'b0;
            instret        <= 64'd0;
            prev_commit_pc <= '0;
        end else begin
            if (halt || halt_set)
                vld_p1 <= 1'b0;
            else if (mem.wb_allow_in)
                vld_p1 <= mem.mem_to_wb_valid;
            if (halt_set)
                halt <= 1'b1;
            if (fire)
                instret <= instret + 64'(cnt);
            if (cnt != '0)
                prev_commit_pc <= cpc;
        end
    end

    // Stage p1: bundle payload, qualified by vld_p1 so it needs no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lane_vld_p1 <= mem.in_lane_valid;
            pc_p1       <= mem.in_pc;
            result_p1   <= mem.in_result;
            wr_en_p1    <= mem.in_rf_wr_en;
            waddr_p1    <= mem.in_rf_waddr;
            ebreak_p1   <= mem.in_ebreak;
        end
    end

    assign wb_valid   = vld_p1;
    assign rf_we      = we;
    assign rf_waddr   = waddr_p1;
    assign rf_wdata   = result_p1;
    assign commit     = (cnt != '0);
    assign commit_cnt = cnt;
    assign commit_pc  = cpc;
endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed and randomised bench for wb_retire_stage with LANES=2, XLEN=32.
module tb_wb_retire_stage;
    localparam int XLEN  = 32;
    localparam int LANES = 2;
    localparam int CNT_W = $clog2(LANES+1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  trace_ready;
    logic                  wb_valid;
    logic [LANES-1:0]      rf_we;
    logic [LANES*5-1:0]    rf_waddr;
    logic [LANES*XLEN-1:0] rf_wdata;
    logic                  commit;
    logic [CNT_W-1:0]      commit_cnt;
    logic [XLEN-1:0]       commit_pc;
    logic [XLEN-1:0]       prev_commit_pc;
    logic [63:0]           instret;
    logic                  halt;

    int checks = 0;
    int errors = 0;

    wb_retire_if #(.XLEN(XLEN), .LANES(LANES)) bus ();

    wb_retire_stage #(.XLEN(XLEN), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem            (bus.slave),
        .trace_ready    (trace_ready),
        .wb_valid       (wb_valid),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .commit         (commit),
        .commit_cnt     (commit_cnt),
        .commit_pc      (commit_pc),
        .prev_commit_pc (prev_commit_pc),
        .instret        (instret),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    // Register file fed by the write ports; later lanes applied last.
    logic [XLEN-1:0] rf [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) rf[r] <= '0;
        end else begin
            for (int i = 0; i < LANES; i++)
                if (rf_we[i]) rf[rf_waddr[i*5 +: 5]] <= rf_wdata[i*XLEN +: XLEN];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [31:0] pc,
                            input logic [31:0] res, input logic we, input logic [4:0] a,
                            input logic eb);
        bus.in_lane_valid[i]          = v;
        bus.in_pc[i*XLEN +: XLEN]     = pc;
        bus.in_result[i*XLEN +: XLEN] = res;
        bus.in_rf_wr_en[i]            = we;
        bus.in_rf_waddr[i*5 +: 5]     = a;
        bus.in_ebreak[i]              = eb;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
        chk({tag, "_halt"}, 64'(halt), 64'd0);
        chk({tag, "_instret"}, instret, 64'd0);
        chk({tag, "_prev_pc"}, 64'(prev_commit_pc), 64'd0);
        chk({tag, "_commit"}, 64'(commit), 64'd0);
        chk({tag, "_cnt"}, 64'(commit_cnt), 64'd0);
        chk({tag, "_cpc"}, 64'(commit_pc), 64'd0);
        chk({tag, "_rf_we"}, 64'(rf_we), 64'd0);
        chk({tag, "_allow"}, 64'(bus.wb_allow_in), 64'd1);
    endtask

    // Random-phase model state
    logic            m_vld;
    logic [1:0]      m_lv;
    logic [31:0]     m_pc [2];
    logic [1:0]      lv;
    logic            mv;
    int              acc;
    int              cyc;
    logic [63:0]     ref_ir;
    logic [31:0]     ref_prev;
    int              exp_cnt;
    logic [31:0]     exp_pc;

    initial begin
        rst = 1'b1;
        trace_ready = 1'b1;
        bus.mem_to_wb_valid = 1'b0;
        set_lane(0, 0, 0, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_reset_state("rst0");

        // Two independent writes
        set_lane(0, 1, 32'h100, 32'h11, 1, 5'd5, 0);
        set_lane(1, 1, 32'h104, 32'h22, 1, 5'd6, 0);
        bus.mem_to_wb_valid = 1'b1;
        tick();
        bus.mem_to_wb_valid = 1'b0;
        #1;
        chk("a_rf_we", 64'(rf_we), 64'b11);
        chk("a_cnt", 64'(commit_cnt), 64'd2);
        chk("a_cpc", 64'(commit_pc), 64'h104);
        chk("a_commit", 64'(commit), 64'd1);
        chk("a_waddr", 64'(rf_waddr), 64'({5'd6, 5'd5}));
        tick();
        chk("a_instret", instret, 64'd2);
        chk("a_prev", 64'(prev_commit_pc), 64'h104);
        chk("a_x5", 64'(rf[5]), 64'h11);
        chk("a_x6", 64'(rf[6]), 64'h22);
        chk("a_wb_valid", 64'(wb_valid), 64'd0);

        // Same destination: youngest wins
        set_lane(0, 1, 32'h108, 32'hAA, 1, 5'd7, 0);
        set_lane(1, 1, 32'h10C, 32'hBB, 1, 5'd7, 0);
        bus.mem_to_wb_valid = 1'b1;
        tick();
        bus.mem_to_wb_valid = 1'b0;
        #1;
        chk("b_rf_we", 64'(rf_we), 64'b10);
        chk("b_cnt", 64'(commit_cnt), 64'd2);
        tick();
        chk("b_x7", 64'(rf[7]), 64'hBB);
        chk("b_instret", instret, 64'd4);

        // x0 write is dropped but still retires
        set_lane(0, 1, 32'h110, 32'h33, 1, 5'd0, 0);
        set_lane(1, 1, 32'h114, 32'h44, 1, 5'd8, 0);
        bus.mem_to_wb_valid = 1'b1;
        tick();
        bus.mem_to_wb_valid = 1'b0;
        #1;
        chk("c_rf_we", 64'(rf_we), 64'b10);
        chk("c_cnt", 64'(commit_cnt), 64'd2);
        tick();
        chk("c_instret", instret, 64'd6);
        chk("c_x8", 64'(rf[8]), 64'h44);

        // Trace stall for three cycles, next bundle accepted on release
        trace_ready = 1'b0;
        set_lane(0, 1, 32'h118, 32'h55, 1, 5'd10, 0);
        set_lane(1, 1, 32'h11C, 32'h66, 1, 5'd11, 0);
        bus.mem_to_wb_valid = 1'b1;
        tick();
        set_lane(0, 1, 32'h120, 32'h77, 1, 5'd12, 0);
        set_lane(1, 0, 32'h124, 32'h00, 0, 5'd0, 0);
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("d_stall_allow", 64'(bus.wb_allow_in), 64'd0);
            chk("d_stall_we", 64'(rf_we), 64'd0);
            chk("d_stall_commit", 64'(commit), 64'd0);
            chk("d_stall_valid", 64'(wb_valid), 64'd1);
            tick();
        end
        trace_ready = 1'b1;
        #1;
        chk("d_rel_we", 64'(rf_we), 64'b11);
        chk("d_rel_cpc", 64'(commit_pc), 64'h11C);
        chk("d_rel_allow", 64'(bus.wb_allow_in), 64'd1);
        tick();
        bus.mem_to_wb_valid = 1'b0;
        #1;
        chk("d_next_cnt", 64'(commit_cnt), 64'd1);
        chk("d_next_cpc", 64'(commit_pc), 64'h120);
        chk("d_next_we", 64'(rf_we), 64'b01);
        tick();
        chk("d_instret", instret, 64'd9);
        chk("d_prev", 64'(prev_commit_pc), 64'h120);
        chk("d_x10", 64'(rf[10]), 64'h55);
        chk("d_x12", 64'(rf[12]), 64'h77);

        // Empty bundle fires without commit
        set_lane(0, 0, 32'h130, 32'h0, 1, 5'd1, 0);
        set_lane(1, 0, 32'h134, 32'h0, 1, 5'd2, 0);
        bus.mem_to_wb_valid = 1'b1;
        tick();
        bus.mem_to_wb_valid = 1'b0;
        #1;
        chk("e_commit", 64'(commit), 64'd0);
        chk("e_cpc", 64'(commit_pc), 64'd0);
        chk("e_valid", 64'(wb_valid), 64'd1);
        chk("e_we", 64'(rf_we), 64'd0);
        tick();
        chk("e_instret", instret, 64'd9);
        chk("e_prev", 64'(prev_commit_pc), 64'h120);
        chk("e_valid_after", 64'(wb_valid), 64'd0);

        // Ebreak in lane 0 kills lane 1; a following bundle is discarded
        set_lane(0, 1, 32'h200, 32'h0, 0, 5'd0, 1);
        set_lane(1, 1, 32'h204, 32'h99, 1, 5'd9, 0);
        bus.mem_to_wb_valid = 1'b1;
        tick();
        set_lane(0, 1, 32'h300, 32'hEE, 1, 5'd13, 0);
        set_lane(1, 0, 32'h304, 32'h0, 0, 5'd0, 0);
        #1;
        chk("f_cnt", 64'(commit_cnt), 64'd1);
        chk("f_cpc", 64'(commit_pc), 64'h200);
        chk("f_we", 64'(rf_we), 64'd0);
        chk("f_halt_pre", 64'(halt), 64'd0);
        tick();
        chk("f_halt", 64'(halt), 64'd1);
        chk("f_valid", 64'(wb_valid), 64'd0);
        chk("f_instret", instret, 64'd10);
        chk("f_prev", 64'(prev_commit_pc), 64'h200);
        chk("f_x9", 64'(rf[9]), 64'd0);
        for (int s = 0; s < 10; s++) begin
            chk("f_halt_allow", 64'(bus.wb_allow_in), 64'd0);
            chk("f_halt_commit", 64'(commit), 64'd0);
            chk("f_halt_we", 64'(rf_we), 64'd0);
            tick();
        end
        chk("f_x13", 64'(rf[13]), 64'd0);

        // Reset while halted
        bus.mem_to_wb_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_reset_state("rst_halt");

        // Reset while a bundle is stalled
        trace_ready = 1'b0;
        set_lane(0, 1, 32'h380, 32'h5A, 1, 5'd14, 0);
        set_lane(1, 1, 32'h384, 32'h5B, 1, 5'd16, 0);
        bus.mem_to_wb_valid = 1'b1;
        tick();
        bus.mem_to_wb_valid = 1'b0;
        tick();
        chk("g_held", 64'(wb_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_reset_state("rst_stall");
        trace_ready = 1'b1;
        #1;
        chk("g_no_stale_commit", 64'(commit), 64'd0);
        chk("g_no_stale_we", 64'(rf_we), 64'd0);
        set_lane(0, 1, 32'h400, 32'h1234, 1, 5'd15, 0);
        set_lane(1, 0, 32'h404, 32'h0, 0, 5'd0, 0);
        bus.mem_to_wb_valid = 1'b1;
        tick();
        bus.mem_to_wb_valid = 1'b0;
        #1;
        chk("g_resume_we", 64'(rf_we), 64'b01);
        chk("g_resume_cpc", 64'(commit_pc), 64'h400);
        tick();
        chk("g_x14", 64'(rf[14]), 64'd0);
        chk("g_x15", 64'(rf[15]), 64'h1234);
        chk("g_instret", instret, 64'd1);

        // Random back-to-back bundles against a reference count
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_vld = 1'b0;
        m_lv = '0;
        m_pc[0] = '0;
        m_pc[1] = '0;
        acc = 0;
        cyc = 0;
        ref_ir = 64'd0;
        ref_prev = 32'd0;
        while ((acc < 100 || m_vld) && cyc < 3000) begin
            mv = (acc < 100);
            lv = 2'($urandom_range(0, 3));
            trace_ready = ($urandom_range(0, 9) < 7);
            set_lane(0, lv[0], 32'h1000 + 32'(acc) * 8, 32'(acc), 1, 5'd20, 0);
            set_lane(1, lv[1], 32'h1004 + 32'(acc) * 8, 32'(acc) + 1, 1, 5'd21, 0);
            bus.mem_to_wb_valid = mv;
            #1;
            exp_cnt = 0;
            exp_pc = '0;
            if (m_vld && trace_ready) begin
                for (int i = 0; i < 2; i++)
                    if (m_lv[i]) begin
                        exp_cnt++;
                        exp_pc = m_pc[i];
                    end
            end
            chk("r_cnt", 64'(commit_cnt), 64'(exp_cnt));
            chk("r_cpc", 64'(commit_pc), 64'(exp_pc));
            chk("r_allow", 64'(bus.wb_allow_in), 64'(!m_vld || trace_ready));
            if (m_vld && trace_ready) begin
                ref_ir += 64'(exp_cnt);
                if (exp_cnt != 0) ref_prev = exp_pc;
            end
            if (!m_vld || trace_ready) begin
                if (mv) begin
                    m_vld = 1'b1;
                    m_lv = lv;
                    m_pc[0] = 32'h1000 + 32'(acc) * 8;
                    m_pc[1] = 32'h1004 + 32'(acc) * 8;
                    acc++;
                end else begin
                    m_vld = 1'b0;
                end
            end
            cyc++;
            tick();
        end
        bus.mem_to_wb_valid = 1'b0;
        chk("r_finished", 64'(cyc < 3000), 64'd1);
        chk("r_instret", instret, ref_ir);
        chk("r_prev", 64'(prev_commit_pc), 64'(ref_prev));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
